// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes and arbiter state encoding shared by the ALU and its arbiter.
package alu_pkg;
    localparam int ALU_OP_W = 4;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd7;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;
endpackage

// File: rtl/ALU.sv
// ALU: combinational integer ALU; unsupported op codes yield zero and raise err.
module ALU
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [ALU_OP_W-1:0] op,
    output logic [DATA_W-1:0]   result,
    output logic                err
);
    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, a < b};
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters with valid/ready handshakes.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic                      flush,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_err,
    output logic                      busy
);
    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              err_q, err_d;
    logic              any_valid, grant;
    logic [DATA_W-1:0] alu_result;
    logic              alu_err;

    // Contention goes to whoever did not win last time.
    assign any_valid = |req_valid;
    assign grant     = &req_valid ? ~last_grant_q : req_valid[1];

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_q == IDLE && any_valid) req_ready[grant] = 1'b1;
        if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
    end

    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign busy       = state_q != IDLE;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        result_d     = result_q;
        err_d        = err_q;
        case (state_q)
            IDLE: if (any_valid) begin
                state_d      = EXEC;
                owner_d      = grant;
                last_grant_d = grant;
                a_d          = grant ? req_a[DATA_W +: DATA_W] : req_a[DATA_W-1:0];
                b_d          = grant ? req_b[DATA_W +: DATA_W] : req_b[DATA_W-1:0];
                op_d         = grant ? req_op[OP_W +: OP_W] : req_op[OP_W-1:0];
            end
            EXEC: begin
                state_d = flush ? IDLE : RESP;
                if (!flush) begin
                    result_d = alu_result;
                    err_d    = alu_err;
                end
            end
            RESP: if (flush || rsp_ready[owner_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    ALU #(.DATA_W(DATA_W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .err    (alu_err)
    );
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a behavioural model.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [7:0]  req_op = '0;
    logic        flush = 1'b0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        busy;
    int vectors = 0;
    int miscompares = 0;
    int exp_last = 1;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(2), .DATA_W(32), .OP_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .flush      (flush),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLT: return (a < b) ? 32'd1 : 32'd0;
            ALU_SLL: return a << b[4:0];
            ALU_SRL: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] oh(input int r);
        return (r == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic int winner(input logic [1:0] v);
        return (v == 2'b11) ? 1 - exp_last : (v[1] ? 1 : 0);
    endfunction

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req_valid[r] = 1'b1;
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
        req_op[r*4 +: 4] = op;
    endtask

    task automatic await_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid == 2'b00 && n < 20);
    endtask

    task automatic consume(input int r);
        rsp_ready = oh(r);
        @(posedge clk);
        #1 rsp_ready = '0;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
        vectors++; if (rsp_result !== 32'd0) begin miscompares++; $display("FAIL reset_rsp_result got %h exp 0", rsp_result); end
        vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        logic [31:0] as [2] = '{32'd5, 32'd1};
        logic [31:0] bs [2] = '{32'd7, 32'd33};
        logic [3:0]  ops [2] = '{ALU_ADD, ALU_SLL};
        logic [31:0] exp [2] = '{32'd12, 32'd2};
        int n;
        for (int k = 0; k < 2; k++) begin
            set_req(0, as[k], bs[k], ops[k]);
            @(negedge clk);
            vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL basic_ready[%0d] got %b exp 01", k, req_ready); end
            @(posedge clk);
            #1 req_valid = '0;
            exp_last = 0;
            await_rsp(n);
            vectors++; if (n !== 2) begin miscompares++; $display("FAIL basic_latency[%0d] got %0d exp 2", k, n); end
            vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL basic_valid[%0d] got %b exp 01", k, rsp_valid); end
            vectors++; if (rsp_result !== exp[k]) begin miscompares++; $display("FAIL basic_result[%0d] got %h exp %h", k, rsp_result, exp[k]); end
            vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL basic_err[%0d] got %b exp 0", k, rsp_err); end
            consume(0);
        end
    endtask

    task automatic test_contention;
        int n, w;
        logic [31:0] e;
        apply_reset();
        set_req(0, 32'd10, 32'd3, ALU_SUB);
        set_req(1, 32'hF0, 32'hFF, ALU_XOR);
        for (int k = 0; k < 5; k++) begin
            w = winner(req_valid);
            e = ref_res(req_a[w*32 +: 32], req_b[w*32 +: 32], req_op[w*4 +: 4]);
            @(negedge clk);
            vectors++; if (req_ready !== oh(w)) begin miscompares++; $display("FAIL contend_ready[%0d] got %b exp %b", k, req_ready, oh(w)); end
            @(posedge clk);
            #1 exp_last = w;
            await_rsp(n);
            vectors++; if (n !== 2) begin miscompares++; $display("FAIL contend_latency[%0d] got %0d exp 2", k, n); end
            vectors++; if (rsp_valid !== oh(w)) begin miscompares++; $display("FAIL contend_valid[%0d] got %b exp %b", k, rsp_valid, oh(w)); end
            vectors++; if (rsp_result !== e) begin miscompares++; $display("FAIL contend_result[%0d] got %h exp %h", k, rsp_result, e); end
            vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL contend_ready_resp[%0d] got %b exp 00", k, req_ready); end
            consume(w);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        int n;
        set_req(1, 32'h12345000, 32'h678, ALU_ADD);
        @(negedge clk);
        vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL bp_ready got %b exp 10", req_ready); end
        @(posedge clk);
        #1 req_valid = '0;
        exp_last = 1;
        set_req(0, 32'd1, 32'd1, ALU_ADD);
        await_rsp(n);
        for (int i = 0; i < 5; i++) begin
            vectors++; if (rsp_valid !== 2'b10) begin miscompares++; $display("FAIL bp_valid[%0d] got %b exp 10", i, rsp_valid); end
            vectors++; if (rsp_result !== 32'h12345678) begin miscompares++; $display("FAIL bp_result[%0d] got %h exp 12345678", i, rsp_result); end
            vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_req_ready[%0d] got %b exp 00", i, req_ready); end
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy[%0d] got %b exp 1", i, busy); end
            if (i < 4) @(negedge clk);
        end
        consume(1);
        @(negedge clk);
        vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL bp_done_valid got %b exp 00", rsp_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_done_busy got %b exp 0", busy); end
        vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL bp_next_ready got %b exp 01", req_ready); end
        req_valid = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_err_slt;
        logic [31:0] as [2] = '{32'd3, 32'hFFFFFFFF};
        logic [31:0] bs [2] = '{32'd4, 32'd1};
        logic [3:0]  ops [2] = '{4'b1111, ALU_SLT};
        logic        errs [2] = '{1'b1, 1'b0};
        int n, r;
        for (int k = 0; k < 2; k++) begin
            r = int'($urandom_range(0, 1));
            set_req(r, as[k], bs[k], ops[k]);
            @(posedge clk);
            #1 req_valid = '0;
            exp_last = r;
            await_rsp(n);
            vectors++; if (rsp_result !== 32'd0) begin miscompares++; $display("FAIL errslt_result[%0d] got %h exp 0", k, rsp_result); end
            vectors++; if (rsp_err !== errs[k]) begin miscompares++; $display("FAIL errslt_err[%0d] got %b exp %b", k, rsp_err, errs[k]); end
            vectors++; if (rsp_valid !== oh(r)) begin miscompares++; $display("FAIL errslt_valid[%0d] got %b exp %b", k, rsp_valid, oh(r)); end
            consume(r);
        end
    endtask

    task automatic test_flush;
        int n, w;
        logic [31:0] e;
        flush = 1'b1;
        set_req(0, 32'd11, 32'd22, ALU_ADD);
        @(negedge clk);
        vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL flush_idle_ready got %b exp 01", req_ready); end
        @(posedge clk);
        #1 req_valid = '0;
        exp_last = 0;
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL flush_exec_busy got %b exp 1", busy); end
        vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL flush_exec_valid got %b exp 00", rsp_valid); end
        @(posedge clk);
        #1 flush = 1'b0;
        set_req(0, 32'd11, 32'd22, ALU_ADD);
        set_req(1, 32'h80000000, 32'd31, ALU_SRL);
        w = winner(req_valid);
        e = ref_res(req_a[w*32 +: 32], req_b[w*32 +: 32], req_op[w*4 +: 4]);
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_idle_busy got %b exp 0", busy); end
        vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL flush_idle_valid got %b exp 00", rsp_valid); end
        vectors++; if (req_ready !== oh(w)) begin miscompares++; $display("FAIL flush_other_wins got %b exp %b", req_ready, oh(w)); end
        @(posedge clk);
        #1 req_valid = '0;
        exp_last = w;
        await_rsp(n);
        vectors++; if (rsp_result !== e) begin miscompares++; $display("FAIL flush_after_result got %h exp %h", rsp_result, e); end
        flush = 1'b1;
        rsp_ready = oh(w);
        @(posedge clk);
        #1 flush = 1'b0;
        rsp_ready = '0;
        @(negedge clk);
        vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL flush_resp_valid got %b exp 00", rsp_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_resp_busy got %b exp 0", busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset;
        int n;
        set_req(1, 32'hDEAD0000, 32'h0000BEEF, ALU_OR);
        @(posedge clk);
        #1 req_valid = '0;
        exp_last = 1;
        await_rsp(n);
        vectors++; if (rsp_valid !== 2'b10) begin miscompares++; $display("FAIL arst_pre_valid got %b exp 10", rsp_valid); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL arst_valid got %b exp 00", rsp_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy got %b exp 0", busy); end
        vectors++; if (rsp_result !== 32'd0) begin miscompares++; $display("FAIL arst_result got %h exp 0", rsp_result); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = 1;
        @(posedge clk);
        #1 set_req(0, 32'd100, 32'd1, ALU_SUB);
        set_req(1, 32'd1, 32'd1, ALU_ADD);
        @(negedge clk);
        vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL arst_first_grant got %b exp 01", req_ready); end
        @(posedge clk);
        #1 req_valid = '0;
        exp_last = 0;
        await_rsp(n);
        vectors++; if (rsp_result !== 32'd99) begin miscompares++; $display("FAIL arst_result_after got %h exp 99", rsp_result); end
        consume(0);
    endtask

    task automatic test_random;
        int n, w, d;
        logic [1:0] v;
        logic [31:0] e;
        logic ee;
        for (int k = 0; k < 40; k++) begin
            v = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++)
                if (v[r]) set_req(r, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom, 4'($urandom_range(0, 15)));
            w = winner(v);
            e = ref_res(req_a[w*32 +: 32], req_b[w*32 +: 32], req_op[w*4 +: 4]);
            ee = req_op[w*4 + 3];
            @(negedge clk);
            vectors++; if (req_ready !== oh(w)) begin miscompares++; $display("FAIL rand_ready[%0d] got %b exp %b", k, req_ready, oh(w)); end
            @(posedge clk);
            #1 req_valid = '0;
            exp_last = w;
            await_rsp(n);
            vectors++; if (n !== 2) begin miscompares++; $display("FAIL rand_latency[%0d] got %0d exp 2", k, n); end
            vectors++; if (rsp_valid !== oh(w)) begin miscompares++; $display("FAIL rand_valid[%0d] got %b exp %b", k, rsp_valid, oh(w)); end
            vectors++; if (rsp_result !== e) begin miscompares++; $display("FAIL rand_result[%0d] got %h exp %h", k, rsp_result, e); end
            vectors++; if (rsp_err !== ee) begin miscompares++; $display("FAIL rand_err[%0d] got %b exp %b", k, rsp_err, ee); end
            d = int'($urandom_range(0, 3));
            rsp_ready = oh(1 - w);
            for (int i = 0; i < d; i++) @(negedge clk);
            vectors++; if (rsp_valid !== oh(w)) begin miscompares++; $display("FAIL rand_hold[%0d] got %b exp %b", k, rsp_valid, oh(w)); end
            consume(w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_contention();
        test_backpressure();
        test_err_slt();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
